// File: rtl/mcb_pkg.sv
// Shared definitions for the MCB command arbiter.
//   MCB_INSTR_WR / MCB_INSTR_RD : MCB user-port instruction codes
//   MCB_MAX_BL                  : longest legal burst, in 32-bit words
//   arb_state_t                 : command arbiter FSM states
//   len_ok()                    : true when a requested burst length is legal
package mcb_pkg;

  localparam logic [2:0] MCB_INSTR_WR = 3'b000;
  localparam logic [2:0] MCB_INSTR_RD = 3'b001;
  localparam int unsigned MCB_MAX_BL  = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DONE
  } arb_state_t;

  function automatic logic len_ok(input logic [6:0] len);
    return (len != '0) && (len <= 7'(MCB_MAX_BL));
  endfunction

endpackage

// File: rtl/mcb_cmd_arb_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector (bit 0 has priority after reset)
//   advance    : a grant was taken this cycle; move the pointer past it
//   gnt[1:0]   : one-hot grant, or zero when nothing requests
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // ptr = 0 favours req[0], ptr = 1 favours req[1]
  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  // The pointer always lands on the side that was not granted, even when the
  // grant was uncontested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance && (gnt != '0)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/mcb_cmd_arb.sv
// Command arbiter for one MCB user command port shared by a write engine and a
// read engine. Grants round-robin, issues one MCB command per grant and
// returns a one-cycle done pulse to the owner.
//   wr_req/wr_addr/wr_len/wr_done : write requester (level request, done pulse)
//   rd_req/rd_addr/rd_len/rd_done : read requester
//   req_err                       : pulses with *_done when the length was illegal
//   p_cmd_*                       : MCB command port (en, instr, byte_addr, bl)
//   p_cmd_full, p_wr_count        : MCB command FIFO full, write FIFO fill level
//   wr_stall                      : sticky flag, write blocked on FIFO fill too long
//   wr_cmd_cnt, rd_cmd_cnt        : wrapping issued-command counters
module mcb_cmd_arb
  import mcb_pkg::*;
#(
  parameter int unsigned WR_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic [29:0] wr_addr,
  input  logic [6:0]  wr_len,
  output logic        wr_done,
  input  logic        rd_req,
  input  logic [29:0] rd_addr,
  input  logic [6:0]  rd_len,
  output logic        rd_done,
  output logic        req_err,
  output logic        p_cmd_en,
  output logic [2:0]  p_cmd_instr,
  output logic [29:0] p_cmd_byte_addr,
  output logic [5:0]  p_cmd_bl,
  input  logic        p_cmd_full,
  input  logic [6:0]  p_wr_count,
  output logic        wr_stall,
  output logic [15:0] wr_cmd_cnt,
  output logic [15:0] rd_cmd_cnt
);

  localparam logic [11:0] STALL_LIMIT = 12'(WR_TIMEOUT);

  arb_state_t  state, state_nxt;
  logic        wr_elig, rd_elig;
  logic [1:0]  gnt;
  logic        grant, gnt_wr, len_bad;
  logic [6:0]  sel_len;
  logic [29:0] sel_addr;
  logic        own_wr;
  logic        done_set, done_wr;
  logic [10:0] stall_cnt;

  assign wr_elig = wr_req && (p_wr_count >= wr_len);
  assign rd_elig = rd_req;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({rd_elig, wr_elig}),
    .advance (grant),
    .gnt     (gnt)
  );

  assign grant    = (state == ST_IDLE) && (gnt != '0);
  assign gnt_wr   = gnt[0];
  assign sel_len  = gnt_wr ? wr_len  : rd_len;
  assign sel_addr = gnt_wr ? wr_addr : rd_addr;
  assign len_bad  = !len_ok(sel_len);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant) state_nxt = len_bad ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (!p_cmd_full) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    p_cmd_en = (state == ST_ISSUE) && !p_cmd_full;
  end

  // Command latch; a rejected request leaves the last command fields intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_wr          <= 1'b0;
      p_cmd_instr     <= '0;
      p_cmd_byte_addr <= '0;
      p_cmd_bl        <= '0;
    end else if (grant) begin
      own_wr <= gnt_wr;
      if (!len_bad) begin
        p_cmd_instr     <= gnt_wr ? MCB_INSTR_WR : MCB_INSTR_RD;
        p_cmd_byte_addr <= sel_addr & ~30'h3;
        p_cmd_bl        <= 6'(sel_len - 7'd1);
      end
    end
  end

  // A rejection completes at the grant edge, before own_wr is updated, so the
  // owner comes straight from the grant in that case.
  assign done_set = (grant && len_bad) || p_cmd_en;
  assign done_wr  = grant ? gnt_wr : own_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      req_err <= 1'b0;
    end else begin
      wr_done <= done_set && done_wr;
      rd_done <= done_set && !done_wr;
      req_err <= grant && len_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cmd_cnt <= '0;
      rd_cmd_cnt <= '0;
    end else if (p_cmd_en) begin
      if (own_wr) wr_cmd_cnt <= wr_cmd_cnt + 16'd1;
      else        rd_cmd_cnt <= rd_cmd_cnt + 16'd1;
    end
  end

  // Write stall timer: counts cycles a write request waits on FIFO fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      wr_stall  <= 1'b0;
    end else begin
      if (!wr_req || (grant && gnt_wr)) begin
        stall_cnt <= '0;
      end else if (!wr_elig) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 11'd1;
        if (({1'b0, stall_cnt} + 12'd1) >= STALL_LIMIT) wr_stall <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mcb_cmd_arb.sv
module tb_mcb_cmd_arb;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [29:0] wr_addr = '0, rd_addr = '0;
  logic [6:0]  wr_len = '0, rd_len = '0;
  logic        wr_done, rd_done, req_err, p_cmd_en, wr_stall;
  logic [2:0]  p_cmd_instr;
  logic [29:0] p_cmd_byte_addr;
  logic [5:0]  p_cmd_bl;
  logic        p_cmd_full = 1'b0;
  logic [6:0]  p_wr_count = '0;
  logic [15:0] wr_cmd_cnt, rd_cmd_cnt;

  mcb_cmd_arb #(.WR_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_done(rd_done),
    .req_err(req_err), .p_cmd_en(p_cmd_en), .p_cmd_instr(p_cmd_instr),
    .p_cmd_byte_addr(p_cmd_byte_addr), .p_cmd_bl(p_cmd_bl),
    .p_cmd_full(p_cmd_full), .p_wr_count(p_wr_count), .wr_stall(wr_stall),
    .wr_cmd_cnt(wr_cmd_cnt), .rd_cmd_cnt(rd_cmd_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: got event-absent expected event (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model (schedule-level) ----------------
  typedef struct {
    int unsigned cyc;
    logic [2:0]  instr;
    logic [29:0] addr;
    logic [5:0]  bl;
  } cmd_t;
  typedef struct {
    int unsigned cyc;
    bit          wr;
    bit          err;
    logic [15:0] wcnt;
    logic [15:0] rcnt;
  } done_t;

  cmd_t  cmd_q[$];
  done_t done_q[$];

  bit          model_on = 0;
  bit          m_favour_wr = 1;
  bit          m_issuing = 0;
  bit          m_own_wr = 0;
  logic [29:0] m_addr;
  logic [5:0]  m_bl;
  int unsigned m_free_at = 0;
  int unsigned m_stall_run = 0;
  bit          m_stall_set = 0;
  int unsigned m_stall_from = 0;
  logic [15:0] m_nwr = '0, m_nrd = '0;

  task automatic model_clear();
    cmd_q.delete();
    done_q.delete();
    m_favour_wr = 1; m_issuing = 0; m_free_at = 0;
    m_stall_run = 0; m_stall_set = 0; m_nwr = '0; m_nrd = '0;
  endtask

  bit         mw_el, mr_el, m_gw, m_gr, m_bad;
  logic [6:0] m_len;

  // Runs mid-cycle on the inputs the DUT will sample at the next edge.
  always @(negedge clk) begin
    if (model_on) begin
      mw_el = wr_req && (p_wr_count >= wr_len);
      mr_el = rd_req;
      m_gw = 0; m_gr = 0;
      if (m_issuing) begin
        if (!p_cmd_full) begin
          if (m_own_wr) m_nwr++; else m_nrd++;
          cmd_q.push_back('{cyc, m_own_wr ? 3'b000 : 3'b001, m_addr, m_bl});
          done_q.push_back('{cyc + 1, m_own_wr, 1'b0, m_nwr, m_nrd});
          m_issuing = 0;
          m_free_at = cyc + 2;
        end
      end else if (cyc >= m_free_at && (mw_el || mr_el)) begin
        if (mw_el && mr_el) begin m_gw = m_favour_wr; m_gr = !m_favour_wr; end
        else begin m_gw = mw_el; m_gr = mr_el; end
        m_favour_wr = m_gr;
        m_len = m_gw ? wr_len : rd_len;
        m_bad = (m_len == 0) || (m_len > 64);
        if (m_bad) begin
          done_q.push_back('{cyc + 1, m_gw, 1'b1, m_nwr, m_nrd});
          m_free_at = cyc + 2;
        end else begin
          m_issuing = 1;
          m_own_wr  = m_gw;
          m_addr    = (m_gw ? wr_addr : rd_addr) & ~30'h3;
          m_bl      = 6'(m_len - 7'd1);
        end
      end
      if (!wr_req || m_gw) m_stall_run = 0;
      else if (!mw_el) begin
        m_stall_run++;
        if (m_stall_run >= TO && !m_stall_set) begin
          m_stall_set = 1;
          m_stall_from = cyc + 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  cmd_t  mc;
  done_t md;
  always @(negedge clk) begin
    if (model_on) begin
      #1;
      if (model_on) begin
        if (p_cmd_en) begin
          if (cmd_q.size() == 0) fail_now("cmd_unexpected");
          else begin
            mc = cmd_q.pop_front();
            chk("cmd_cycle", 64'(cyc), 64'(mc.cyc));
            chk("cmd_instr", 64'(p_cmd_instr), 64'(mc.instr));
            chk("cmd_addr", 64'(p_cmd_byte_addr), 64'(mc.addr));
            chk("cmd_bl", 64'(p_cmd_bl), 64'(mc.bl));
          end
        end else if (cmd_q.size() > 0 && cmd_q[0].cyc <= cyc) begin
          fail_now("cmd_missing");
          void'(cmd_q.pop_front());
        end

        if (wr_done && rd_done) fail_now("done_both_sides");
        else if (wr_done || rd_done) begin
          if (done_q.size() == 0) fail_now("done_unexpected");
          else begin
            md = done_q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(md.cyc));
            chk("done_side", 64'(wr_done), 64'(md.wr));
            chk("req_err", 64'(req_err), 64'(md.err));
            chk("wr_cmd_cnt", 64'(wr_cmd_cnt), 64'(md.wcnt));
            chk("rd_cmd_cnt", 64'(rd_cmd_cnt), 64'(md.rcnt));
          end
        end else begin
          if (req_err) fail_now("req_err_without_done");
          if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
            fail_now("done_missing");
            void'(done_q.pop_front());
          end
        end

        chk("wr_stall", 64'(wr_stall), 64'(m_stall_set && (cyc >= m_stall_from)));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_req = 0; rd_req = 0; p_cmd_full = 0;
  endtask

  task automatic do_reset();
    model_on = 0;
    idle_inputs();
    rst_n = 0;
    repeat (3) step();
    model_clear();
    rst_n = 1;
    model_on = 1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (!m_issuing && cmd_q.size() == 0 && done_q.size() == 0 && cyc >= m_free_at) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  task automatic wait_done(input bit wr, input string name);
    bit seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (wr ? wr_done : rd_done) begin seen = 1; break; end
    end
    if (!seen) fail_now(name);
  endtask

  function automatic logic [6:0] pick_len();
    int unsigned r = $urandom_range(19);
    if (r == 0) return 7'd0;
    if (r == 1) return 7'($urandom_range(127, 65));
    return 7'($urandom_range(64, 1));
  endfunction

  bit wr_act, rd_act;
  int unsigned ndone;

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_p_cmd_en", 64'(p_cmd_en), 0);
    chk("rst_wr_done", 64'(wr_done), 0);
    chk("rst_rd_done", 64'(rd_done), 0);
    chk("rst_req_err", 64'(req_err), 0);
    chk("rst_wr_stall", 64'(wr_stall), 0);
    chk("rst_cmd_fields", {p_cmd_instr, p_cmd_byte_addr, p_cmd_bl}, 0);
    chk("rst_counters", {wr_cmd_cnt, rd_cmd_cnt}, 0);
    do_reset();

    // Single read
    rd_addr = 30'h400; rd_len = 7'd64; rd_req = 1;
    wait_done(0, "single_read_timeout");
    rd_req = 0;
    wait_idle();
    chk("single_read_cnt", 64'(rd_cmd_cnt), 1);

    // Contention from reset: W, R, W, R ...
    do_reset();
    p_wr_count = 7'd127;
    wr_addr = 30'h100; wr_len = 7'd16; wr_req = 1;
    rd_addr = 30'h200; rd_len = 7'd32; rd_req = 1;
    ndone = 0;
    for (int i = 0; i < 80 && ndone < 10; i++) begin
      step();
      if (wr_done) begin ndone++; wr_addr = $urandom; wr_len = 7'($urandom_range(64, 1)); end
      if (rd_done) begin ndone++; rd_addr = $urandom; rd_len = 7'($urandom_range(64, 1)); end
      if (ndone >= 10) begin wr_req = 0; rd_req = 0; end
    end
    idle_inputs();
    wait_idle();
    chk("contention_wr_cnt", 64'(wr_cmd_cnt), 5);
    chk("contention_rd_cnt", 64'(rd_cmd_cnt), 5);

    // Back-pressure during ISSUE
    rd_addr = 30'h803; rd_len = 7'd8; rd_req = 1; p_cmd_full = 1;
    repeat (6) step();
    p_cmd_full = 0;
    wait_done(0, "backpressure_timeout");
    rd_req = 0;
    wait_idle();

    // Rejected read
    rd_addr = 30'h40; rd_len = 7'd0; rd_req = 1;
    wait_done(0, "reject_timeout");
    chk("reject_err", 64'(req_err), 1);
    rd_req = 0;
    wait_idle();

    // Write gated on FIFO fill, stall flag
    do_reset();
    p_wr_count = 7'd10;
    wr_addr = 30'h1234567; wr_len = 7'd64; wr_req = 1;
    repeat (10) step();
    chk("stall_set", 64'(wr_stall), 1);
    while (p_wr_count < 7'd64) begin
      p_wr_count = (p_wr_count + 7'd9 > 7'd64) ? 7'd64 : p_wr_count + 7'd9;
      step();
    end
    wait_done(1, "gated_write_timeout");
    wr_req = 0;
    wait_idle();

    // Randomised traffic
    do_reset();
    wr_act = 0; rd_act = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (wr_done) begin wr_act = 0; wr_req = 0; end
      if (rd_done) begin rd_act = 0; rd_req = 0; end
      if (!wr_act && $urandom_range(3) == 0) begin
        wr_addr = $urandom; wr_len = pick_len(); wr_req = 1; wr_act = 1;
      end
      if (!rd_act && $urandom_range(3) == 0) begin
        rd_addr = $urandom; rd_len = pick_len(); rd_req = 1; rd_act = 1;
      end
      if (m_issuing && m_own_wr && wr_req && $urandom_range(7) == 0) wr_req = 0;
      if (m_issuing && !m_own_wr && rd_req && $urandom_range(7) == 0) rd_req = 0;
      if (wr_act && $urandom_range(3) != 0) p_wr_count = 7'($urandom_range(127, wr_len));
      else p_wr_count = 7'($urandom_range(127));
      p_cmd_full = ($urandom_range(3) == 0);
    end
    idle_inputs();
    wait_idle();

    // Asynchronous reset while in ISSUE
    rd_addr = 30'h3FFFFFF3; rd_len = 7'd16; rd_req = 1; p_cmd_full = 1;
    repeat (2) step();
    model_on = 0;
    rst_n = 0;
    #1;
    chk("arst_p_cmd_en", 64'(p_cmd_en), 0);
    chk("arst_dones", {wr_done, rd_done, req_err}, 0);
    chk("arst_wr_stall", 64'(wr_stall), 0);
    chk("arst_cmd_fields", {p_cmd_instr, p_cmd_byte_addr, p_cmd_bl}, 0);
    chk("arst_counters", {wr_cmd_cnt, rd_cmd_cnt}, 0);
    rd_req = 0; p_cmd_full = 0;
    repeat (2) step();
    model_clear();
    rst_n = 1;
    model_on = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_reset_no_done", {wr_done, rd_done, p_cmd_en}, 0);
    end
    repeat (2) step();
    model_on = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mcb_cmd_arb.md
# mcb_cmd_arb

Two-requester command arbiter for one MCB user command port, shared by the DDR3 test write and read engines. It grants round-robin between a write requester and a read requester. A write is granted only once its full burst is in the MCB write FIFO. The arbiter then issues exactly one MCB command per grant and returns a one-cycle done pulse to the owner.

## Interface
- `WR_TIMEOUT`, default 1023: cycles a write request may sit blocked on FIFO fill before `wr_stall` sets.
- `clk` in 1: system clock, all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_req` in 1: write command request; level, held until `wr_done`.
- `wr_addr` in 30: write byte address.
- `wr_len` in 7: write burst length in 32-bit words, valid 1..64.
- `wr_done` out 1: one-cycle pulse when the write command is issued or rejected.
- `rd_req`, `rd_addr`, `rd_len`, `rd_done`: read-side equivalents with identical widths and rules.
- `req_err` out 1: pulse alongside `*_done` when the request was rejected.
- `p_cmd_en` out 1: MCB command strobe.
- `p_cmd_instr` out 3: MCB instruction; 3'b000 = write, 3'b001 = read.
- `p_cmd_byte_addr` out 30: MCB command address.
- `p_cmd_bl` out 6: MCB burst length minus 1.
- `p_cmd_full` in 1: MCB command FIFO full.
- `p_wr_count` in 7: words currently in the MCB write FIFO.
- `wr_stall` out 1: sticky debug flag; cleared only by reset.
- `wr_cmd_cnt`, `rd_cmd_cnt` out 16 each: issued-command counters; wrap at 16'hFFFF→0.

## Operation
- Reset value of all outputs is 0. Initial state is IDLE. The round-robin pointer favours write after reset.
- FSM states: IDLE, ISSUE, DONE.
- IDLE, eligibility rules:
  - A write is eligible when `wr_req` is high and `p_wr_count >= wr_len`.
  - A read is eligible when `rd_req` is high.
- IDLE, arbitration:
  - If both requesters are eligible, grant the one favoured by the pointer. The pointer then favours the other requester.
  - If only one is eligible, grant it regardless of the pointer; the pointer still toggles to the non-granted side.
  - A blocked write never blocks an eligible read.
- IDLE, latch and transition:
  - On grant, latch instr, addr with `[1:0]` forced to 0, and `bl = len-1` (low 6 bits).
  - Go to ISSUE.
- IDLE, length check:
  - Before the grant, `len == 0` or `len > 64` rejects the request.
  - A rejected request goes to DONE with `req_err` set and issues no command. It still consumes the grant and toggles the pointer.
- ISSUE:
  - Hold in ISSUE while `p_cmd_full` is high; `p_cmd_en` stays low during this time.
  - When `p_cmd_full` is low, drive `p_cmd_en` high for exactly one cycle, increment the matching counter, and go to DONE.
- DONE: pulse the owner's `*_done` for one cycle (plus `req_err` if rejected), then return to IDLE.
- Once granted, a command is committed. If the requester drops `*_req` during ISSUE, the command is still issued and `*_done` still pulses.
- Stall counter:
  - An 11-bit counter increments while `wr_req` is high and the write is not eligible.
  - It clears when `wr_req` is low, or when the write is granted.
  - Reaching `WR_TIMEOUT` sets `wr_stall`.
- Asynchronous reset mid-operation:
  - All state, counters and flags clear immediately.
  - Any in-flight grant is discarded with no `*_done` pulse; the requester must re-request after reset.

## Timing
- Latency, unblocked: request eligible in IDLE at cycle N → `p_cmd_en` at N+1 → `*_done` at N+2.
- Minimum spacing between grants is 3 cycles.
- `p_cmd_instr`, `p_cmd_byte_addr` and `p_cmd_bl` are registered. They are stable from entry into ISSUE through the `p_cmd_en` cycle and hold their last value afterwards.
- `*_done` and `req_err` are registered one-cycle pulses and are never asserted together on both sides.
- The requester must not change `*_addr` or `*_len` while `*_req` is high and before `*_done`.

## Structure
- Shared package `mcb_pkg` holds:
  - instruction constants MCB_INSTR_WR and MCB_INSTR_RD;
  - MCB_MAX_BL = 64;
  - the FSM state encoding.
- One sub-module: `rr_arb2`, a 2-way round-robin arbiter with pointer register. Inputs are `req[1:0]` and `advance`; outputs are `gnt[1:0]` (one-hot or zero).
- All remaining logic lives in the top module: FSM, latches, stall timer and counters.

## Test plan
- Single read: `rd_req=1`, addr 30'h400, len 64 → `p_cmd_en` one cycle with instr 001, addr 30'h400, bl 63; `rd_done` 2 cycles after the request; `rd_cmd_cnt = 1`.
- Write gated on FIFO:
  - Stimulus: `wr_req`, len 64, `p_wr_count` ramping from 0 to 64.
  - Response: no `p_cmd_en` until count = 64, then issue with instr 000, bl 63.
  - With `WR_TIMEOUT = 8` and count held at 10, `wr_stall` sets after 8 cycles.
- Contention: both requesters held continuously eligible → grants alternate W, R, W, R; after 10 commands each counter reads 5.
- Back-pressure: `p_cmd_full` high for 5 cycles during ISSUE → `p_cmd_en` low throughout; it asserts in the first cycle after full deasserts; `*_done` follows one cycle later.
- Rejection and reset:
  - `rd_len = 0` → `rd_done` and `req_err` pulse together with no `p_cmd_en`.
  - `rst_n` low while in ISSUE → all outputs 0 immediately, with no done pulse afterwards.
